// File: rtl/biu_if.sv
// Request/acknowledge bus between the two CPU masters, the BIU and the external 16-bit memory port.
// Latency: none (wires only).
// Backpressure: the requester holds its req/adr/we/dtw stable until ack; the memory stalls with m_rdy.
//
// Signals:
//   i_*  instruction fetch port (prefetch unit): req, adr, abort in; ack, dtr out
//   d_*  load/store port (execute stage): req, we, adr, dtw in; ack, dtr out
//   m_*  external memory: cs, we, adr, dout out; din, rdy in
// Modports: slave = the BIU's view; master = the environment (both requesters and the memory).
interface biu_if;
  logic        i_req;
  logic [19:0] i_adr;
  logic        i_abort;
  logic        i_ack;
  logic [15:0] i_dtr;

  logic        d_req;
  logic        d_we;
  logic [19:0] d_adr;
  logic [15:0] d_dtw;
  logic        d_ack;
  logic [15:0] d_dtr;

  logic        m_cs;
  logic        m_we;
  logic [19:0] m_adr;
  logic [15:0] m_dout;
  logic [15:0] m_din;
  logic        m_rdy;

  modport slave (
    input  i_req, i_adr, i_abort, d_req, d_we, d_adr, d_dtw, m_din, m_rdy,
    output i_ack, i_dtr, d_ack, d_dtr, m_cs, m_we, m_adr, m_dout
  );

  modport master (
    output i_req, i_adr, i_abort, d_req, d_we, d_adr, d_dtw, m_din, m_rdy,
    input  i_ack, i_dtr, d_ack, d_dtr, m_cs, m_we, m_adr, m_dout
  );
endinterface

// File: rtl/biu.sv
// Bus interface unit: arbitrates instruction fetch vs load/store onto one 16-bit memory port.
// Latency: 3 cycles minimum per word (IDLE grant, ACC for max(WAIT+1, m_rdy), one-cycle ACK).
// Backpressure: one access at a time; requesters wait for ack, memory stalls ACC via m_rdy.
//
// Ports: clk, rst_n (async active-low), bus (biu_if.slave: i_* fetch port, d_* data port, m_* memory).
// Parameter WAIT (0..15): minimum ACC cycles before m_rdy is honoured.
// Optional macro BIU_FAIR_EN: after two consecutive data grants made while i_req was high, the
// next grant goes to instruction. Without it data has strict priority.
module biu #(
  parameter int unsigned WAIT = 1
) (
  input logic  clk,
  input logic  rst_n,
  biu_if.slave bus
);

  localparam logic [3:0] WAIT_C = 4'(WAIT);

  typedef enum logic [1:0] {IDLE, ACC, ACK} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_win_d;   // latched winner: 1 = data port, 0 = instruction port
  logic        r_we;
  logic        r_abort;   // instruction access flushed while in flight
  logic [19:0] r_adr;
  logic [15:0] r_dout;
  logic        r_m_cs;
  logic        r_i_ack;
  logic        r_d_ack;
  logic [15:0] r_i_dtr;
  logic [15:0] r_d_dtr;
`ifdef BIU_FAIR_EN
  logic [1:0]  r_fair;    // consecutive data grants taken while i_req was waiting
`endif

  logic w_grant_i;
  logic w_grant_d;
  logic w_done;
  logic w_abort_now;

  always_comb begin
`ifdef BIU_FAIR_EN
    w_grant_i = bus.i_req && (!bus.d_req || (r_fair == 2'd2));
`else
    w_grant_i = bus.i_req && !bus.d_req;
`endif
    w_grant_d   = bus.d_req && !w_grant_i;
    w_done      = (r_cnt >= WAIT_C) && bus.m_rdy;
    // An abort on the exit edge itself must also suppress the ack.
    w_abort_now = !r_win_d && (r_abort || bus.i_abort);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_win_d <= 1'b0;
      r_we    <= 1'b0;
      r_abort <= 1'b0;
      r_adr   <= '0;
      r_dout  <= '0;
      r_m_cs  <= 1'b0;
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      r_i_dtr <= '0;
      r_d_dtr <= '0;
`ifdef BIU_FAIR_EN
      r_fair  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_abort <= 1'b0;
          if (w_grant_i || w_grant_d) begin
            r_state <= ACC;
            r_cnt   <= '0;
            r_win_d <= w_grant_d;
            r_adr   <= w_grant_d ? bus.d_adr : bus.i_adr;
            r_we    <= w_grant_d && bus.d_we;
            r_dout  <= w_grant_d ? bus.d_dtw : 16'h0000;
            r_m_cs  <= 1'b1;
`ifdef BIU_FAIR_EN
            if (w_grant_i || !bus.i_req)
              r_fair <= '0;
            else if (r_fair != 2'd2)
              r_fair <= r_fair + 2'd1;
`endif
          end
        end

        ACC: begin
          if (!r_win_d && bus.i_abort)
            r_abort <= 1'b1;
          if (w_done) begin
            r_state <= ACK;
            r_m_cs  <= 1'b0;
            if (r_win_d) begin
              r_d_ack <= 1'b1;
              if (!r_we)
                r_d_dtr <= bus.m_din;
            end else if (!w_abort_now) begin
              r_i_ack <= 1'b1;
              r_i_dtr <= bus.m_din;
            end
          end else if (r_cnt != 4'hF) begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        ACK: begin
          // The ack was already presented for this whole cycle; nothing left to suppress.
          r_i_ack <= 1'b0;
          r_d_ack <= 1'b0;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.m_cs   = r_m_cs;
  assign bus.m_we   = r_m_cs && r_we;
  assign bus.m_adr  = r_adr;
  assign bus.m_dout = r_dout;
  assign bus.i_ack  = r_i_ack;
  assign bus.i_dtr  = r_i_dtr;
  assign bus.d_ack  = r_d_ack;
  assign bus.d_dtr  = r_d_dtr;

endmodule
